// File: rtl/mem_access.sv
// RV64 load/store unit between execute and writeback: one outstanding memory
// access, lane-positioned store data, sign/zero-extended load data, registered result.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] result_i,
  input  logic [63:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o,
  output logic [4:0]  out_rd_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } state_t;

  state_t      state_q, state_d;

  logic [63:0] addr_q;
  logic [2:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;

  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        misalign_q, misalign_d;

  logic        out_free;
  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        start_mem;
  logic [7:0]  size_mask;
  logic [63:0] rshift;
  logic [63:0] load_data;

  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q == IDLE) && out_free;
  assign accept     = in_valid_i && in_ready_o;
  assign is_mem     = is_load_i || is_store_i;
  assign start_mem  = accept && is_mem && !misaligned;

  // Reserved size code 111 is reported the same way as a misaligned access.
  always_comb begin
    misaligned = 1'b0;
    if (funct3_i == 3'b111) begin
      misaligned = 1'b1;
    end else begin
      case (funct3_i[1:0])
        2'b01:   misaligned = result_i[0];
        2'b10:   misaligned = |result_i[1:0];
        2'b11:   misaligned = |result_i[2:0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    size_mask = 8'h01;
    case (funct3_i[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign rshift = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_data = rshift;
    case (f3_q)
      3'b000:  load_data = {{56{rshift[7]}},  rshift[7:0]};
      3'b001:  load_data = {{48{rshift[15]}}, rshift[15:0]};
      3'b010:  load_data = {{32{rshift[31]}}, rshift[31:0]};
      3'b100:  load_data = {56'd0, rshift[7:0]};
      3'b101:  load_data = {48'd0, rshift[15:0]};
      3'b110:  load_data = {32'd0, rshift[31:0]};
      default: load_data = rshift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_mem) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt_i) state_d = we_q ? IDLE : WAIT_R;
      end
      WAIT_R: begin
        if (mem_rvalid_i && out_free) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (start_mem) begin
      addr_q  <= {result_i[63:3], 3'b000};
      off_q   <= result_i[2:0];
      f3_q    <= funct3_i;
      rd_q    <= rd_i;
      we_q    <= is_store_i;
      wdata_q <= wdata_i << {result_i[2:0], 3'b000};
      wstrb_q <= size_mask << result_i[2:0];
    end
  end

  // Result register: a new result always wins over clearing, and a pending
  // result is held untouched until the consumer takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    misalign_d  = misalign_q;
    if (accept && !is_mem) begin
      out_valid_d = 1'b1;
      out_data_d  = result_i;
      out_rd_d    = rd_i;
      misalign_d  = 1'b0;
    end else if (accept && misaligned) begin
      out_valid_d = 1'b1;
      out_data_d  = '0;
      out_rd_d    = '0;
      misalign_d  = 1'b1;
    end else if ((state_q == REQ) && mem_gnt_i && we_q) begin
      out_valid_d = 1'b1;
      out_data_d  = '0;
      out_rd_d    = '0;
      misalign_d  = 1'b0;
    end else if ((state_q == WAIT_R) && mem_rvalid_i && out_free) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
      out_rd_d    = rd_q;
      misalign_d  = 1'b0;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = (state_q == REQ) && we_q;
  assign mem_wstrb_o = ((state_q == REQ) && we_q) ? wstrb_q : '0;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_rd_o    = out_rd_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, stores, loads, faults,
// backpressure and reset behaviour, all against hand-computed values.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [63:0] result_i;
  logic [63:0] wdata_i;
  logic [4:0]  rd_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_data_o;
  logic [4:0]  out_rd_o;
  logic        misalign_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .result_i     (result_i),
    .wdata_i      (wdata_i),
    .rd_i         (rd_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_rd_o     (out_rd_o),
    .misalign_o   (misalign_o)
  );

  task automatic drive_idle();
    in_valid_i   = 1'b0;
    is_load_i    = 1'b0;
    is_store_i   = 1'b0;
    funct3_i     = 3'b000;
    result_i     = '0;
    wdata_i      = '0;
    rd_i         = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    out_ready_i  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    #2;
    vectors++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_wstrb_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mem req=%b we=%b wstrb=%h want 0/0/00", mem_req_o, mem_we_o, mem_wstrb_o);
    end
    vectors++;
    if (out_valid_o !== 1'b0 || out_data_o !== 64'd0 || out_rd_o !== 5'd0 || misalign_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out valid=%b data=%h rd=%0d mis=%b want 0/0/0/0",
               out_valid_o, out_data_o, out_rd_o, misalign_o);
    end
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got %b want 1", in_ready_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    in_valid_i = 1'b1;
    result_i   = 64'h1234;
    rd_i       = 5'd5;
    #1;
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_in_ready got %b want 1", in_ready_o);
    end
    @(negedge clk);
    drive_idle();
    vectors++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'h1234 || out_rd_o !== 5'd5 || misalign_o !== 1'b0
        || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_out valid=%b data=%h rd=%0d mis=%b req=%b want 1/1234/5/0/0",
               out_valid_o, out_data_o, out_rd_o, misalign_o, mem_req_o);
    end
    @(negedge clk);
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_clear valid got %b want 0", out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    in_valid_i = 1'b1;
    result_i   = 64'hAAAA_0000_0000_0001;
    rd_i       = 5'd1;
    @(negedge clk);
    result_i   = 64'h5555_0000_0000_0002;
    rd_i       = 5'd2;
    #1;
    vectors++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'hAAAA_0000_0000_0001 || out_rd_o !== 5'd1
        || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first valid=%b data=%h rd=%0d rdy=%b want 1/aaaa000000000001/1/1",
               out_valid_o, out_data_o, out_rd_o, in_ready_o);
    end
    @(negedge clk);
    drive_idle();
    vectors++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'h5555_0000_0000_0002 || out_rd_o !== 5'd2) begin
      miscompares++;
      $display("FAIL b2b_second valid=%b data=%h rd=%0d want 1/5555000000000002/2",
               out_valid_o, out_data_o, out_rd_o);
    end
    @(negedge clk);
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] exp_strb,
                            input logic [63:0] exp_wdata, input int unsigned waits);
    in_valid_i = 1'b1;
    is_store_i = 1'b1;
    funct3_i   = f3;
    result_i   = addr;
    wdata_i    = wdata;
    rd_i       = 5'd9;
    @(negedge clk);
    drive_idle();
    for (int unsigned i = 0; i <= waits; i++) begin
      vectors++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== {addr[63:3], 3'b000}
          || mem_wstrb_o !== exp_strb || mem_wdata_o !== exp_wdata) begin
        miscompares++;
        $display("FAIL %s_req[%0d] req=%b we=%b addr=%h strb=%h wdata=%h want 1/1/%h/%h/%h",
                 name, i, mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
                 {addr[63:3], 3'b000}, exp_strb, exp_wdata);
      end
      if (i == waits) mem_gnt_i = 1'b1;
      @(negedge clk);
    end
    mem_gnt_i = 1'b0;
    vectors++;
    if (mem_req_o !== 1'b0 || out_valid_o !== 1'b1 || out_data_o !== 64'd0 || out_rd_o !== 5'd0
        || misalign_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done req=%b valid=%b data=%h rd=%0d mis=%b want 0/1/0/0/0",
               name, mem_req_o, out_valid_o, out_data_o, out_rd_o, misalign_o);
    end
    @(negedge clk);
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp, input logic [4:0] rd);
    in_valid_i = 1'b1;
    is_load_i  = 1'b1;
    funct3_i   = f3;
    result_i   = addr;
    rd_i       = rd;
    @(negedge clk);
    drive_idle();
    vectors++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_wstrb_o !== 8'h00
        || mem_addr_o !== {addr[63:3], 3'b000}) begin
      miscompares++;
      $display("FAIL %s_req req=%b we=%b strb=%h addr=%h want 1/0/00/%h",
               name, mem_req_o, mem_we_o, mem_wstrb_o, mem_addr_o, {addr[63:3], 3'b000});
    end
    // A stray response while still requesting must be ignored.
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = ~rdata;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    vectors++;
    if (mem_req_o !== 1'b1 || out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_rvalid_in_req req=%b valid=%b want 1/0", name, mem_req_o, out_valid_o);
    end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    vectors++;
    if (mem_req_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_wait req=%b valid=%b rdy=%b want 0/0/0", name, mem_req_o, out_valid_o, in_ready_o);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    vectors++;
    if (out_valid_o !== 1'b1 || out_data_o !== exp || out_rd_o !== rd || misalign_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_data valid=%b data=%h rd=%0d mis=%b want 1/%h/%0d/0",
               name, out_valid_o, out_data_o, out_rd_o, misalign_o, exp, rd);
    end
    @(negedge clk);
    vectors++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_after valid=%b rdy=%b want 0/1", name, out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_misalign(input string name, input logic [2:0] f3, input logic [63:0] addr,
                               input logic store);
    in_valid_i = 1'b1;
    is_load_i  = !store;
    is_store_i = store;
    funct3_i   = f3;
    result_i   = addr;
    wdata_i    = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_i       = 5'd7;
    @(negedge clk);
    drive_idle();
    vectors++;
    if (mem_req_o !== 1'b0 || out_valid_o !== 1'b1 || misalign_o !== 1'b1
        || out_data_o !== 64'd0 || out_rd_o !== 5'd0) begin
      miscompares++;
      $display("FAIL %s_fault req=%b valid=%b mis=%b data=%h rd=%0d want 0/1/1/0/0",
               name, mem_req_o, out_valid_o, misalign_o, out_data_o, out_rd_o);
    end
    @(negedge clk);
    vectors++;
    if (mem_req_o !== 1'b0 || out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_after req=%b valid=%b want 0/0", name, mem_req_o, out_valid_o);
    end
  endtask

  task automatic test_backpressure();
    in_valid_i  = 1'b1;
    is_load_i   = 1'b1;
    funct3_i    = 3'b100;
    result_i    = 64'h2005;
    rd_i        = 5'd12;
    out_ready_i = 1'b0;
    @(negedge clk);
    in_valid_i = 1'b0;
    is_load_i  = 1'b0;
    mem_gnt_i  = 1'b1;
    @(negedge clk);
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'h0000_8000_0000_0000;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    // Offer a new ALU op during the stall; it must not be taken.
    in_valid_i   = 1'b1;
    result_i     = 64'hDEAD;
    rd_i         = 5'd3;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (out_valid_o !== 1'b1 || out_data_o !== 64'h80 || out_rd_o !== 5'd12 || in_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] valid=%b data=%h rd=%0d rdy=%b want 1/80/12/0",
                 i, out_valid_o, out_data_o, out_rd_o, in_ready_o);
      end
      @(negedge clk);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    #1;
    vectors++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'h80 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release valid=%b data=%h rdy=%b want 1/80/1", out_valid_o, out_data_o, in_ready_o);
    end
    @(negedge clk);
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_single valid got %b want 0", out_valid_o);
    end
    @(negedge clk);
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_second valid got %b want 0", out_valid_o);
    end
    drive_idle();
  endtask

  task automatic test_reset_midflight();
    // Asynchronous reset while requesting.
    in_valid_i = 1'b1;
    is_load_i  = 1'b1;
    funct3_i   = 3'b011;
    result_i   = 64'h7000;
    rd_i       = 5'd4;
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_req_async req=%b rdy=%b want 0/1", mem_req_o, in_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Reset while waiting for the response; a late response is ignored.
    in_valid_i = 1'b1;
    is_load_i  = 1'b1;
    funct3_i   = 3'b011;
    result_i   = 64'h7000;
    rd_i       = 5'd4;
    @(negedge clk);
    drive_idle();
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    vectors++;
    if (out_valid_o !== 1'b0 || mem_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_late_rvalid valid=%b req=%b rdy=%b want 0/0/1", out_valid_o, mem_req_o, in_ready_o);
    end
    @(negedge clk);
    vectors++;
    if (out_valid_o !== 1'b0 || out_data_o !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_after valid=%b data=%h want 0/0", out_valid_o, out_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_store("sb", 3'b000, 64'h1003, 64'hAB, 8'h08, 64'h0000_0000_AB00_0000, 3);
    test_store("sh", 3'b001, 64'h100A, 64'hBEEF, 8'h0C, 64'h0000_0000_BEEF_0000, 0);
    test_store("sw", 3'b010, 64'h1004, 64'h1122_3344, 8'hF0, 64'h1122_3344_0000_0000, 1);
    test_store("sd", 3'b011, 64'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 0);
    test_load("lb",  3'b000, 64'h2005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 5'd10);
    test_load("lbu", 3'b100, 64'h2005, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080, 5'd11);
    test_load("lh",  3'b001, 64'h4006, 64'h8765_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8765, 5'd13);
    test_load("lhu", 3'b101, 64'h4006, 64'h8765_0000_0000_0000, 64'h0000_0000_0000_8765, 5'd14);
    test_load("lw",  3'b010, 64'h5004, 64'h9ABC_DEF0_1111_2222, 64'hFFFF_FFFF_9ABC_DEF0, 5'd15);
    test_load("lwu", 3'b110, 64'h5004, 64'h9ABC_DEF0_1111_2222, 64'h0000_0000_9ABC_DEF0, 5'd16);
    test_load("lw0", 3'b010, 64'h5000, 64'h9ABC_DEF0_1111_2222, 64'h0000_0000_1111_2222, 5'd17);
    test_load("ld",  3'b011, 64'h6000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 5'd31);
    test_misalign("lw_mis",  3'b010, 64'h3002, 1'b0);
    test_misalign("sh_mis",  3'b001, 64'h1001, 1'b1);
    test_misalign("sd_mis",  3'b011, 64'h1004, 1'b1);
    test_misalign("rsv_f3",  3'b111, 64'h8000, 1'b0);
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters: none; data path fixed at 64 bits, register index 5 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid_i  in  1  upstream (execute) presents an operation.
REQ-005 in_ready_o  out  1  block accepts the operation this cycle.
REQ-006 is_load_i / is_store_i  in  1 each  operation class; both low = non-memory op.
REQ-007 funct3_i  in  3  RV64 load/store size/sign code.
REQ-008 result_i  in  64  execute result: byte address for load/store, ALU value otherwise.
REQ-009 wdata_i  in  64  store data (rs2 value).
REQ-010 rd_i  in  5  destination register.
REQ-011 mem_req_o, mem_we_o  out  1 each  memory request, write enable.
REQ-012 mem_addr_o  out  64  8-byte-aligned address (result_i with bits [2:0] cleared).
REQ-013 mem_wdata_o  out  64; mem_wstrb_o  out  8  lane-positioned store data, byte strobes.
REQ-014 mem_gnt_i  in  1  request accepted; mem_rvalid_i  in  1, mem_rdata_i  in  64  read response.
REQ-015 out_valid_o  out  1; out_ready_i  in  1  writeback handshake.
REQ-016 out_data_o  out  64; out_rd_o  out  5; misalign_o  out  1  writeback value, register, fault flag.

Function
REQ-017 States: IDLE, REQ, WAIT_R.
REQ-018 in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i); transfer when in_valid_i && in_ready_o.
REQ-019 Non-memory op accepted: next cycle out_valid_o=1, out_data_o=result_i, out_rd_o=rd_i, misalign_o=0; state stays IDLE.
REQ-020 Misaligned (halfword addr[0]=1; word addr[1:0]!=0; double addr[2:0]!=0): no memory request; next cycle out_valid_o=1, misalign_o=1, out_data_o=0, out_rd_o=0.
REQ-021 Aligned load/store accepted: IDLE->REQ; address, funct3, rd, lane offset registered.
REQ-022 In REQ: mem_req_o=1; held with stable address/data/strobes until mem_gnt_i=1.
REQ-023 Store strobes: size 1/2/4/8 bytes (funct3[1:0]) shifted left by addr[2:0]; mem_wdata_o = wdata_i << (8*addr[2:0]).
REQ-024 Store granted: REQ->IDLE; next cycle out_valid_o=1, out_data_o=0, out_rd_o=0.
REQ-025 Load in REQ: mem_we_o=0, mem_wstrb_o=0; on grant REQ->WAIT_R.
REQ-026 mem_rvalid_i is sampled only in WAIT_R; ignored in IDLE and REQ.
REQ-027 In WAIT_R on mem_rvalid_i: data = mem_rdata_i >> (8*offset), truncated to size; sign-extend for LB/LH/LW (000/001/010), zero-extend for LBU/LHU/LWU (100/101/110), LD (011) unmodified; out_valid_o=1 next cycle with out_rd_o=rd; ->IDLE.
REQ-028 Output register holds all out_* stable while out_valid_o && !out_ready_i; out_valid_o clears on out_ready_i with no new result.
REQ-029 Load completion and output hold: WAIT_R waits in place (rvalid not consumed) if out_valid_o && !out_ready_i.
REQ-030 Reserved funct3 (111) on load/store: treated as misaligned fault (REQ-020).
REQ-031 Latency: non-memory 1 cycle; store 1 + grant wait; load 1 + grant wait + response wait.

Reset
REQ-032 rst_n low, any state: state=IDLE, mem_req_o=0, mem_we_o=0, mem_wstrb_o=0, out_valid_o=0, out_data_o=0, out_rd_o=0, misalign_o=0, immediately and asynchronously.
REQ-033 Reset mid-transaction abandons the access; a late mem_rvalid_i after reset is ignored (REQ-026).

Verification
REQ-034 ALU pass-through: result_i=0x1234, rd_i=5, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=0x1234, out_rd_o=5.
REQ-035 SB: addr=0x1003, wdata=0xAB -> mem_addr_o=0x1000, mem_wstrb_o=0x08, mem_wdata_o[31:24]=0xAB; held until mem_gnt_i after 3 wait cycles.
REQ-036 LB/LBU: addr=0x2005, mem_rdata_i=0x0000_8000_0000_0000 -> LB out 0xFFFF_FFFF_FFFF_FF80; LBU out 0x80.
REQ-037 LW addr=0x3002 -> misalign_o=1, out_data_o=0, mem_req_o never asserted.
REQ-038 Backpressure: out_ready_i=0 for 4 cycles after a load result -> out_* stable, in_ready_o=0; release -> one transfer only.
REQ-039 Reset in WAIT_R, then mem_rvalid_i=1 after release -> no out_valid_o, state IDLE, in_ready_o=1.
